// File: rtl/clk_ctrl_pkg.sv
// Shared state encoding, default timing constants and parameter helpers
// for the core sleep/wake controller.
package clk_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_GATED    = 3'd0,
    ST_WAKE     = 3'd1,
    ST_RUN      = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_RES_HOLD = 3'd4
  } state_e;

  localparam int unsigned DEF_RES_DELAY     = 10;
  localparam int unsigned DEF_HOLD_CYCLES   = 2;
  localparam int unsigned DEF_DRAIN_TIMEOUT = 255;

  // A zero-length phase would make the counter load underflow, so 0 means 1.
  function automatic int unsigned at_least_one(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sleep_cnt.sv
// Shared down-counter for the sleep controller: load, saturating
// decrement and zero detect.
module sleep_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         res,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: state is written only here, with <=, so every flop samples the
  // pre-edge value of its inputs; blocking assignments belong in always_comb.
  always_ff @(posedge clk) begin
    if (res) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/core_sleep_ctrl.sv
// Core clock/reset sequencer: drains, resets and gates the core on sleep,
// and restarts it with a timed reset release on wake.
module core_sleep_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned RES_DELAY     = DEF_RES_DELAY,
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int unsigned DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
  input  logic clk,
  input  logic res,
  input  logic sleep_req,
  input  logic wake_req,
  input  logic core_idle,
  output logic clk_en,
  output logic core_res_n,
  output logic sleep_ack,
  output logic awake,
  output logic drain_timeout
);

  localparam int unsigned RES_D   = at_least_one(RES_DELAY);
  localparam int unsigned HOLD_C  = at_least_one(HOLD_CYCLES);
  localparam int unsigned DRAIN_T = at_least_one(DRAIN_TIMEOUT);
  localparam int unsigned CNT_W   = $clog2(max3(RES_D, HOLD_C, DRAIN_T) + 1);

  localparam logic [CNT_W-1:0] LD_WAKE  = CNT_W'(RES_D - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_C - 1);
  localparam logic [CNT_W-1:0] LD_DRAIN = CNT_W'(DRAIN_T);

  state_e           state_d, state_q;
  logic             wake_pend_d, wake_pend_q;
  logic             drain_timeout_d, drain_timeout_q;
  logic             clk_en_d, clk_en_q;
  logic             core_res_n_d, core_res_n_q;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val;

  sleep_cnt #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .res      (res),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d         = state_q;
    wake_pend_d     = wake_pend_q;
    drain_timeout_d = drain_timeout_q;
    cnt_load        = 1'b0;
    cnt_dec         = 1'b0;
    cnt_val         = '0;

    case (state_q)
      ST_GATED: begin
        if (wake_req) begin
          state_d         = ST_WAKE;
          cnt_load        = 1'b1;
          cnt_val         = LD_WAKE;
          drain_timeout_d = 1'b0;
        end
      end
      ST_WAKE: begin
        if (cnt_zero) state_d = ST_RUN;
        else          cnt_dec = 1'b1;
      end
      ST_RUN: begin
        if (sleep_req) begin
          state_d  = ST_DRAIN;
          cnt_load = 1'b1;
          cnt_val  = LD_DRAIN;
        end
      end
      ST_DRAIN: begin
        // A fresh wake outranks the core going idle; timeout is the last resort.
        if (wake_req && !sleep_req) begin
          state_d = ST_RUN;
        end else if (core_idle || cnt_zero) begin
          state_d     = ST_RES_HOLD;
          cnt_load    = 1'b1;
          cnt_val     = LD_HOLD;
          wake_pend_d = 1'b0;
          if (!core_idle) drain_timeout_d = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RES_HOLD: begin
        if (cnt_zero) begin
          if (wake_pend_q || wake_req) begin
            state_d         = ST_WAKE;
            cnt_load        = 1'b1;
            cnt_val         = LD_WAKE;
            wake_pend_d     = 1'b0;
            drain_timeout_d = 1'b0;
          end else begin
            state_d = ST_GATED;
          end
        end else begin
          cnt_dec = 1'b1;
          if (wake_req) wake_pend_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_GATED;
        wake_pend_d = 1'b0;
      end
    endcase

    // Outputs follow the next state so they register in step with it;
    // reset is released only in states where the clock also runs.
    clk_en_d     = (state_d != ST_GATED);
    core_res_n_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q         <= ST_GATED;
      wake_pend_q     <= 1'b0;
      drain_timeout_q <= 1'b0;
      clk_en_q        <= 1'b0;
      core_res_n_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      wake_pend_q     <= wake_pend_d;
      drain_timeout_q <= drain_timeout_d;
      clk_en_q        <= clk_en_d;
      core_res_n_q    <= core_res_n_d;
    end
  end

  assign clk_en        = clk_en_q;
  assign core_res_n    = core_res_n_q;
  assign sleep_ack     = (state_q == ST_GATED);
  assign awake         = (state_q == ST_RUN);
  assign drain_timeout = drain_timeout_q;

endmodule

// File: doc/core_sleep_ctrl.md
CORE_SLEEP_CTRL -- requirements
Module: core_sleep_ctrl

Interface
REQ-001 SHALL have parameter RES_DELAY, default 10: cycles of running clock with core reset held before release on wake.
REQ-002 SHALL have parameter HOLD_CYCLES, default 2: cycles of running clock with core reset asserted before the clock is gated.
REQ-003 SHALL have parameter DRAIN_TIMEOUT, default 255: maximum DRAIN cycles before a forced shutdown.
REQ-004 SHALL have port clk  in  1  the single clock; all logic on posedge.
REQ-005 SHALL have port res  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port sleep_req  in  1  level, request core shutdown.
REQ-007 SHALL have port wake_req  in  1  level, request core start.
REQ-008 SHALL have port core_idle  in  1  high when the core has no outstanding bus transaction.
REQ-009 SHALL have port clk_en  out  1  registered enable for the external clock buffer (BUFGCE CE).
REQ-010 SHALL have port core_res_n  out  1  registered active-low core reset.
REQ-011 SHALL have port sleep_ack  out  1  high while in GATED.
REQ-012 SHALL have port awake  out  1  high while in RUN.
REQ-013 SHALL have port drain_timeout  out  1  sticky; set on forced shutdown, cleared by res or on entry to WAKE.

Function
REQ-014 SHALL implement the states GATED, WAKE, RUN, DRAIN and RES_HOLD, with one shared down-counter.
REQ-015 GATED SHALL drive clk_en=0, core_res_n=0 and sleep_ack=1; wake_req=1 SHALL move to WAKE and load the counter with RES_DELAY-1.
REQ-016 WAKE SHALL drive clk_en=1 and core_res_n=0; the counter decrements each cycle, and when it reaches 0 the state moves to RUN.
REQ-017 With wake_req sampled at edge t in GATED: clk_en=1 from t+1; core_res_n=1 and awake=1 from t+1+RES_DELAY.
REQ-018 RUN SHALL drive clk_en=1, core_res_n=1 and awake=1; sleep_req=1 SHALL move to DRAIN, load the counter with DRAIN_TIMEOUT and ignore wake_req.
REQ-019 DRAIN SHALL keep the clock running and the core out of reset; the counter decrements each cycle.
REQ-020 In DRAIN, core_idle=1 SHALL move to RES_HOLD and load the counter with HOLD_CYCLES-1.
REQ-021 In DRAIN, a counter value of 0 with core_idle=0 SHALL set drain_timeout and move to RES_HOLD.
REQ-022 In DRAIN, wake_req=1 with sleep_req=0 SHALL abort the shutdown and return to RUN the next cycle; wake_req has priority over core_idle.
REQ-023 RES_HOLD SHALL drive clk_en=1 and core_res_n=0 for exactly HOLD_CYCLES cycles, then move to GATED.
REQ-024 A wake_req=1 sampled during RES_HOLD SHALL be latched as wake_pend; at hold end the FSM goes to WAKE instead of GATED and wake_pend clears.
REQ-025 In RUN, sleep_req and wake_req both high in the same cycle SHALL take sleep.
REQ-026 In GATED, sleep_req and wake_req both high in the same cycle SHALL take wake.
REQ-027 Counter widths SHALL be $clog2(max parameter + 1); parameter values of 0 SHALL be treated as 1.
REQ-028 core_res_n SHALL never be 1 while clk_en is 0 in the same cycle.

Reset
REQ-029 res=1 SHALL force, at the next edge: state GATED, counter 0, wake_pend 0, clk_en=0, core_res_n=0, sleep_ack=1, awake=0, drain_timeout=0.
REQ-030 A res asserted in any state mid-sequence SHALL abort it, with the same result as REQ-029.
REQ-031 Out of reset, the core SHALL stay off until wake_req=1.
REQ-032 Any illegal state encoding SHALL return to GATED.

Structure
REQ-033 The state enum and default parameter constants SHALL live in package clk_ctrl_pkg.
REQ-034 Down-counter load/decrement/zero-detect SHALL be sub-module sleep_cnt, instantiated once.
REQ-035 The block SHALL contain no clock buffer primitive; clk_en drives an external BUFGCE.

Verification
REQ-036 Bench: res high 3 cycles then low; wake_req pulse at cycle 5 -> clk_en=1 at cycle 6, core_res_n=1 and awake=1 at cycle 16.
REQ-037 Bench: RUN, sleep_req=1, core_idle=1 at the next cycle -> core_res_n=0 for 2 clocked cycles, then clk_en=0 and sleep_ack=1; drain_timeout=0.
REQ-038 Bench: DRAIN_TIMEOUT=16, core_idle stuck at 0 -> RES_HOLD entered 17 cycles after DRAIN entry, drain_timeout=1.
REQ-039 Bench: wake_req=1 in DRAIN before core_idle -> back to RUN the next cycle; core_res_n stays 1 throughout.
REQ-040 Bench: wake_req during RES_HOLD -> no cycle with clk_en=0; WAKE follows, core_res_n=1 after 10 cycles.
REQ-041 Bench: res asserted mid-WAKE at counter=4 -> next cycle clk_en=0, core_res_n=0, state GATED; assertion for REQ-028 holds throughout all scenarios.
